// File: rtl/dot_accum.sv
// Dot-product accumulator: sums a programmable number of signed terms per vector
// and emits one result per vector via a 2-entry output FIFO. Saturating adds: DOT_ACCUM_SAT_EN.
module dot_accum #(
    parameter int DW    = 32,
    parameter int AW    = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [AW-1:0]    out_data,
    output logic             out_ovf,
    input  logic             out_ready
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state, state_next;
    logic [AW-1:0]    acc, acc_next;
    logic [LEN_W-1:0] cnt, cnt_next, len_q, len_next;
    logic             ovf, ovf_next;

    logic [AW-1:0]    slot1_data;
    logic             slot1_ovf;
    logic [1:0]       count;

    logic             accept, pop, push, push_ovf, add_ovf;
    logic [AW-1:0]    term, sum_wrap, sum, push_data;
    logic [LEN_W-1:0] len_eff, cnt_inc;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign term     = AW'($signed(in_data));
    assign sum_wrap = acc + term;
    assign add_ovf  = (acc[AW-1] == term[AW-1]) && (sum_wrap[AW-1] != acc[AW-1]);
    assign len_eff  = (len == '0) ? LEN_W'(1) : len;
    assign cnt_inc  = cnt + LEN_W'(1);

`ifdef DOT_ACCUM_SAT_EN
    // Clamp toward the sign of the operands; later adds continue from the clamp.
    assign sum = !add_ovf ? sum_wrap :
                 acc[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
`else
    assign sum = sum_wrap;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            len_q <= len_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        len_next   = len_q;
        ovf_next   = ovf;
        push       = 1'b0;
        push_data  = term;
        push_ovf   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_next = term;
                    cnt_next = LEN_W'(1);
                    len_next = len_eff;
                    ovf_next = 1'b0;
                    if (len_eff == LEN_W'(1)) push = 1'b1;
                    else                      state_next = ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_next = sum;
                    cnt_next = cnt_inc;
                    ovf_next = ovf | add_ovf;
                    if (cnt_inc == len_q) begin
                        push       = 1'b1;
                        push_data  = sum;
                        push_ovf   = ovf | add_ovf;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Head lives directly in out_data/out_ovf; slot1 holds the second entry.
    // A push with a coinciding pop (or into an empty FIFO) goes straight to the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count      <= 2'd0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            slot1_data <= '0;
            slot1_ovf  <= 1'b0;
        end else if (pop && count == 2'd2) begin
            out_data <= slot1_data;
            out_ovf  <= slot1_ovf;
            count    <= 2'd1;
        end else if (push && (count == 2'd0 || pop)) begin
            out_data <= push_data;
            out_ovf  <= push_ovf;
            count    <= 2'd1;
        end else if (push) begin
            slot1_data <= push_data;
            slot1_ovf  <= push_ovf;
            count      <= 2'd2;
        end else if (pop) begin
            count <= 2'd0;
        end
    end

endmodule

// File: tb/tb_dot_accum.sv
// Directed self-checking bench for dot_accum (AW=40 default instance plus an AW=34 instance).
// Expected values follow DOT_ACCUM_SAT_EN when it is defined for the build.
module tb_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_data;
    logic        out_ovf;
    logic        out_ready = 1'b1;

    logic [7:0]  len34 = '0;
    logic        in_valid34 = 1'b0;
    logic [31:0] in_data34 = '0;
    logic        in_ready34;
    logic        out_valid34;
    logic [33:0] out_data34;
    logic        out_ovf34;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dot_accum #(.DW(32), .AW(40), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .len(len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ovf(out_ovf), .out_ready(out_ready)
    );

    dot_accum #(.DW(32), .AW(34), .LEN_W(8)) dut34 (
        .clk(clk), .rst_n(rst_n), .len(len34), .in_valid(in_valid34), .in_data(in_data34),
        .in_ready(in_ready34), .out_valid(out_valid34), .out_data(out_data34),
        .out_ovf(out_ovf34), .out_ready(1'b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one term and hold it until accepted; inputs stay driven afterwards.
    task automatic send(input bit sel34, input logic [31:0] d);
        bit done = 0;
        if (sel34) begin in_valid34 = 1'b1; in_data34 = d; end
        else       begin in_valid   = 1'b1; in_data   = d; end
        for (int i = 0; i < 20 && !done; i++) begin
            done = sel34 ? in_ready34 : in_ready;
            tick();
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: term %h not accepted within 20 cycles", d);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_valid34 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 40'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_len4();
        out_ready = 1'b1; len = 8'd4;
        send(0, 32'd1); send(0, 32'd2); send(0, 32'd3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len4_early_valid: got %b want 0", out_valid); end
        send(0, 32'd4);
        idle_inputs();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL len4_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 40'd10) begin errors++; $display("FAIL len4_data: got %h want %h", out_data, 40'd10); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL len4_ovf: got %b want 0", out_ovf); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL len4_single_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_len_zero();
        len = 8'd0;
        send(0, 32'd7);
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_data !== 40'd7) begin errors++; $display("FAIL len0_data: got v=%b %h want v=1 %h", out_valid, out_data, 40'd7); end
        len = 8'd2;
        send(0, 32'd5); send(0, 32'd6);
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_data !== 40'd11) begin errors++; $display("FAIL len2_after_len0: got v=%b %h want v=1 %h", out_valid, out_data, 40'd11); end
        tick();
    endtask

    task automatic test_negative();
        len = 8'd2;
        send(0, 32'hFFFF_FFFF); send(0, 32'hFFFF_FFFE);
        idle_inputs();
        checks++; if (out_data !== 40'hFF_FFFF_FFFD) begin errors++; $display("FAIL neg_data: got %h want %h", out_data, 40'hFF_FFFF_FFFD); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b want 0", out_ovf); end
        tick();
    endtask

    task automatic test_len_change_and_gap();
        len = 8'd3;
        send(0, 32'd10);
        idle_inputs(); len = 8'd1;
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_no_output: got %b want 0", out_valid); end
        send(0, 32'd20); send(0, 32'd30);
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_data !== 40'd60) begin errors++; $display("FAIL gap_len_latched: got v=%b %h want v=1 %h", out_valid, out_data, 40'd60); end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; len = 8'd1;
        send(0, 32'd1); send(0, 32'd2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_data = 32'd3;   // held while full
        tick(); tick();
        checks++; if (in_ready !== 1'b0 || out_data !== 40'd1) begin errors++; $display("FAIL full_hold: got rdy=%b %h want rdy=0 %h", in_ready, out_data, 40'd1); end
        out_ready = 1'b1;
        tick();   // pop 1, term 3 not yet accepted
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== 40'd2) begin errors++; $display("FAIL pop1: got rdy=%b v=%b %h want rdy=1 v=1 %h", in_ready, out_valid, out_data, 40'd2); end
        tick();   // pop 2 and push 3 together
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 40'd3) begin errors++; $display("FAIL pop2_push3: got v=%b %h want v=1 %h", out_valid, out_data, 40'd3); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow34();
        logic [33:0] exp;
`ifdef DOT_ACCUM_SAT_EN
        exp = 34'h1_FFFF_FFFF;
`else
        exp = 34'h2_7FFF_FFFB;
`endif
        len34 = 8'd5;
        for (int i = 0; i < 5; i++) send(1, 32'h7FFF_FFFF);
        idle_inputs();
        checks++; if (out_valid34 !== 1'b1 || out_data34 !== exp) begin errors++; $display("FAIL ovf34_data: got v=%b %h want v=1 %h", out_valid34, out_data34, exp); end
        checks++; if (out_ovf34 !== 1'b1) begin errors++; $display("FAIL ovf34_flag: got %b want 1", out_ovf34); end
        tick();
    endtask

    task automatic test_reset_mid_vector();
        len = 8'd4;
        send(0, 32'd100); send(0, 32'd200);
        idle_inputs();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        len = 8'd2;
        send(0, 32'd3); send(0, 32'd4);
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_data !== 40'd7) begin errors++; $display("FAIL midreset_next: got v=%b %h want v=1 %h", out_valid, out_data, 40'd7); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_len4();
        test_len_zero();
        test_negative();
        test_len_change_and_gap();
        test_back_to_back();
        test_overflow34();
        test_reset_mid_vector();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
